// File: rtl/elevator_door_ctrl_pkg.sv
// Shared definitions for the elevator door controller: state encoding,
// default door timing reused by the car controller, and the output decode.
package elevator_door_ctrl_pkg;

    localparam logic [1:0] DOOR_CLOSED    = 2'b00;
    localparam logic [1:0] DOOR_OPENING   = 2'b01;
    localparam logic [1:0] DOOR_OPEN_HOLD = 2'b10;
    localparam logic [1:0] DOOR_CLOSING   = 2'b11;

    localparam int DOOR_MOVE_CYCLES = 2;
    localparam int DOOR_HOLD_CYCLES = 3;

    typedef struct packed {
        logic open_cmd;
        logic close_cmd;
        logic is_open;
        logic closed;
    } door_drive_t;

    // Motor drive and status flags are a pure function of the door state.
    function automatic door_drive_t door_decode(input logic [1:0] st);
        door_drive_t d;
        d = door_drive_t'(4'b0000);
        case (st)
            DOOR_CLOSED:    d.closed    = 1'b1;
            DOOR_OPENING:   d.open_cmd  = 1'b1;
            DOOR_OPEN_HOLD: d.is_open   = 1'b1;
            DOOR_CLOSING:   d.close_cmd = 1'b1;
            default:        d.closed    = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/door_phase_timer.sv
// Shared phase timer for the door FSM: synchronous clear, saturating count,
// and a terminal-count flag against a duration supplied by the current state.
module door_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] n,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Phase count: cleared on request, otherwise counts up and parks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r != CNT_MAX) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // Leaving on done makes a state last exactly n cycles.
    assign done = (count_r == (n - CNT_ONE));

endmodule

// File: rtl/elevator_door_ctrl.sv
// Elevator car door sequencer: CLOSED -> OPENING -> OPEN_HOLD -> CLOSING.
// Optional nudge mode (limits button reopens) is built when DOOR_NUDGE_EN is defined.
module elevator_door_ctrl
    import elevator_door_ctrl_pkg::*;
#(
    parameter int MOVE_CYCLES = DOOR_MOVE_CYCLES,
    parameter int HOLD_CYCLES = DOOR_HOLD_CYCLES,
    parameter int CNT_W       = 4,
    parameter int REOPEN_MAX  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive,
    input  logic       open_btn,
    input  logic       close_btn,
    input  logic       obstruct,
    output logic       door_open_cmd,
    output logic       door_close_cmd,
    output logic       door_is_open,
    output logic       door_closed,
    output logic [1:0] state_o,
    output logic       nudge
);

    localparam int               RW         = $clog2(REOPEN_MAX + 1);
    localparam logic [RW-1:0]    REOPEN_TOP = RW'(REOPEN_MAX);
    localparam logic [RW-1:0]    REOPEN_ONE = RW'(1);
    localparam logic [CNT_W-1:0] MOVE_N     = CNT_W'(MOVE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_N     = CNT_W'(HOLD_CYCLES);

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [RW-1:0]    reopen_cnt_r;
    logic [RW-1:0]    reopen_next_s;
    logic             open_req_s;
    logic             reopen_req_s;
    logic             hold_restart_s;
    logic             phase_clr_s;
    logic             phase_done_s;
    logic [CNT_W-1:0] phase_n_s;
    door_drive_t      drive_r;
    door_drive_t      drive_next_s;

    assign open_req_s = arrive | open_btn;

`ifdef DOOR_NUDGE_EN
    logic nudge_mode_s;
    logic nudge_r;

    // Once the reopen budget is spent, only the safety sensor may reopen the door.
    assign nudge_mode_s = (reopen_cnt_r == REOPEN_TOP);
    assign reopen_req_s = obstruct | (open_req_s & ~nudge_mode_s);
`else
    assign reopen_req_s = obstruct | open_req_s;
`endif

    // Next-state, timer duration and reopen bookkeeping.
    always_comb begin
        next_state_s   = state_r;
        reopen_next_s  = reopen_cnt_r;
        hold_restart_s = 1'b0;
        phase_n_s      = MOVE_N;
        case (state_r)
            DOOR_CLOSED: begin
                if (open_req_s) begin
                    next_state_s = DOOR_OPENING;
                end else begin
                    next_state_s = DOOR_CLOSED;
                end
            end
            DOOR_OPENING: begin
                if (phase_done_s) begin
                    next_state_s = DOOR_OPEN_HOLD;
                end else begin
                    next_state_s = DOOR_OPENING;
                end
            end
            DOOR_OPEN_HOLD: begin
                phase_n_s = HOLD_N;
                if (obstruct | open_req_s) begin
                    hold_restart_s = 1'b1;
                end else if (close_btn | phase_done_s) begin
                    next_state_s = DOOR_CLOSING;
                end else begin
                    next_state_s = DOOR_OPEN_HOLD;
                end
            end
            DOOR_CLOSING: begin
                if (reopen_req_s) begin
                    next_state_s = DOOR_OPENING;
                    if (reopen_cnt_r != REOPEN_TOP) begin
                        reopen_next_s = reopen_cnt_r + REOPEN_ONE;
                    end else begin
                        reopen_next_s = reopen_cnt_r;
                    end
                end else if (phase_done_s) begin
                    next_state_s  = DOOR_CLOSED;
                    reopen_next_s = {RW{1'b0}};
                end else begin
                    next_state_s = DOOR_CLOSING;
                end
            end
            default: begin
                next_state_s  = DOOR_CLOSED;
                reopen_next_s = {RW{1'b0}};
            end
        endcase
    end

    assign phase_clr_s  = hold_restart_s | (next_state_s != state_r);
    assign drive_next_s = door_decode(next_state_s);

    door_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (phase_clr_s),
        .n     (phase_n_s),
        .done  (phase_done_s)
    );

    // State, reopen count and decoded drive outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= DOOR_CLOSED;
            reopen_cnt_r <= {RW{1'b0}};
            drive_r      <= door_decode(DOOR_CLOSED);
        end else begin
            state_r      <= next_state_s;
            reopen_cnt_r <= reopen_next_s;
            drive_r      <= drive_next_s;
        end
    end

`ifdef DOOR_NUDGE_EN
    // Buzzer sounds for the whole of a close attempt made with the budget spent.
    always_ff @(posedge clk) begin
        if (reset) begin
            nudge_r <= 1'b0;
        end else begin
            nudge_r <= (next_state_s == DOOR_CLOSING) && (reopen_next_s == REOPEN_TOP);
        end
    end

    assign nudge = nudge_r;
`else
    assign nudge = 1'b0;
`endif

    assign state_o        = state_r;
    assign door_open_cmd  = drive_r.open_cmd;
    assign door_close_cmd = drive_r.close_cmd;
    assign door_is_open   = drive_r.is_open;
    assign door_closed    = drive_r.closed;

endmodule

// File: tb/tb_elevator_door_ctrl.sv
// Scoreboard bench for elevator_door_ctrl: a time-remaining reference model
// queues expected outputs per edge; a negedge monitor pops and compares.
module tb_elevator_door_ctrl;

    localparam int MOVE = 2;
    localparam int HOLD = 3;
    localparam int RMAX = 3;
    localparam int S_CLOSED  = 0;
    localparam int S_OPENING = 1;
    localparam int S_HOLD    = 2;
    localparam int S_CLOSING = 3;
`ifdef DOOR_NUDGE_EN
    localparam bit NUDGE_ON = 1'b1;
`else
    localparam bit NUDGE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arrive = 1'b0;
    logic       open_btn = 1'b0;
    logic       close_btn = 1'b0;
    logic       obstruct = 1'b0;
    logic       door_open_cmd;
    logic       door_close_cmd;
    logic       door_is_open;
    logic       door_closed;
    logic [1:0] state_o;
    logic       nudge;

    typedef struct packed {
        logic [8:0] v;
        logic       chk;
        logic [1:0] tbl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    // Reference model: which phase the door is in and how many cycles remain in it.
    int m_st = S_CLOSED;
    int m_left = 0;
    int m_reopen = 0;

    always #5 clk = ~clk;

    elevator_door_ctrl #(
        .MOVE_CYCLES (MOVE),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (4),
        .REOPEN_MAX  (RMAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .arrive         (arrive),
        .open_btn       (open_btn),
        .close_btn      (close_btn),
        .obstruct       (obstruct),
        .door_open_cmd  (door_open_cmd),
        .door_close_cmd (door_close_cmd),
        .door_is_open   (door_is_open),
        .door_closed    (door_closed),
        .state_o        (state_o),
        .nudge          (nudge)
    );

    task automatic enter(input int st);
        m_st   = st;
        m_left = (st == S_HOLD) ? HOLD : MOVE;
    endtask

    task automatic model_edge(input bit a, input bit o, input bit c, input bit ob, input bit r);
        bit req;
        bit may_reopen;
        req = a | o;
        if (r) begin
            m_st = S_CLOSED;
            m_left = 0;
            m_reopen = 0;
        end else if (m_st == S_CLOSED) begin
            if (req) enter(S_OPENING);
        end else if (m_st == S_OPENING) begin
            if (m_left == 1) enter(S_HOLD);
            else m_left--;
        end else if (m_st == S_HOLD) begin
            if (ob || req) m_left = HOLD;
            else if (c || m_left == 1) enter(S_CLOSING);
            else m_left--;
        end else begin
            may_reopen = ob || (req && !(NUDGE_ON && m_reopen == RMAX));
            if (may_reopen) begin
                if (m_reopen < RMAX) m_reopen++;
                enter(S_OPENING);
            end else if (m_left == 1) begin
                enter(S_CLOSED);
                m_reopen = 0;
            end else begin
                m_left--;
            end
        end
    endtask

    function automatic logic [8:0] expected_vec();
        return {2'(m_st), m_st == S_OPENING, m_st == S_CLOSING, m_st == S_HOLD,
                m_st == S_CLOSED, NUDGE_ON && m_st == S_CLOSING && m_reopen == RMAX,
                2'(m_reopen)};
    endfunction

    task automatic step(input bit a, input bit o, input bit c, input bit ob, input bit r,
                        input bit chk, input int tbl);
        exp_t e;
        arrive = a;
        open_btn = o;
        close_btn = c;
        obstruct = ob;
        reset = r;
        model_edge(a, o, c, ob, r);
        e.v = expected_vec();
        e.chk = chk;
        e.tbl = 2'(tbl);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int target, input int maxc);
        for (int i = 0; i < maxc && m_st != target; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // One arrive from CLOSED, with the cycle-by-cycle state timeline pinned down.
    task automatic run_nominal();
        int tl[7] = '{1, 2, 2, 2, 3, 3, 0};
        step(1, 0, 0, 0, 0, 1, S_OPENING);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 1, tl[i]);
    endtask

    // Stimulus: directed scenarios followed by biased random traffic.
    initial begin
        step(0, 0, 0, 0, 1, 1, S_CLOSED);
        step(0, 0, 0, 0, 0, 1, S_CLOSED);
        run_nominal();
        // obstruction restarts the hold
        step(1, 0, 0, 0, 0, 0, 0);
        idle_until(S_HOLD, 10);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
        idle_until(S_CLOSED, 20);
        // close button cuts the hold short
        step(1, 0, 0, 0, 0, 0, 0);
        idle_until(S_HOLD, 10);
        step(0, 0, 1, 0, 0, 0, 0);
        idle_until(S_CLOSED, 20);
        // reopen from CLOSING
        step(1, 0, 0, 0, 0, 0, 0);
        idle_until(S_CLOSING, 20);
        step(0, 1, 0, 0, 0, 0, 0);
        idle_until(S_CLOSED, 30);
        // reset mid-OPENING and mid-CLOSING, then nominal timing again
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, S_CLOSED);
        run_nominal();
        step(1, 0, 0, 0, 0, 0, 0);
        idle_until(S_CLOSING, 20);
        step(0, 0, 0, 0, 1, 1, S_CLOSED);
        run_nominal();
        // repeated button reopens until the budget is spent, then obstruction
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            idle_until(S_CLOSING, 20);
            step(0, 1, 0, 0, 0, 0, 0);
        end
        idle_until(S_CLOSING, 20);
        step(0, 0, 0, 1, 0, 0, 0);
        idle_until(S_CLOSED, 40);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(15) == 0, $urandom_range(11) == 0, $urandom_range(5) == 0,
                 $urandom_range(9) == 0, $urandom_range(199) == 0, 0, 0);
        end
        @(negedge clk);
        #1;
        done = 1'b1;
    end

    // Monitor: outputs are valid every cycle; pop one expectation per cycle.
    initial begin
        exp_t e;
        logic [8:0] act;
        while (!done) begin
            @(negedge clk);
            if (!done && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                act = {state_o, door_open_cmd, door_close_cmd, door_is_open, door_closed,
                       nudge, dut.reopen_cnt_r};
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, act, e.v);
                end
                if (e.chk) begin
                    checks++;
                    if (state_o !== e.tbl || door_closed !== (e.tbl == 2'b00)) begin
                        failures++;
                        $display("FAIL timeline cyc=%0d got state=%b closed=%b exp state=%b",
                                 cyc, state_o, door_closed, e.tbl);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
